// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage.
//   - ALU opcode encodings (OP_NOP .. OP_MUL); 4'hD..4'hF are treated as NOP.
//   - carry_sel codes that choose where the C flag comes from.
//   - Bit positions of Z, N and C inside the 3-bit condition-code register.
//   - ccr_next(): builds the next CCR value from the result flags and carry_sel.
package exec_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_NOT   = 4'h1;
    localparam logic [3:0] OP_INC   = 4'h2;
    localparam logic [3:0] OP_DEC   = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_SUB   = 4'h5;
    localparam logic [3:0] OP_AND   = 4'h6;
    localparam logic [3:0] OP_OR    = 4'h7;
    localparam logic [3:0] OP_SHL   = 4'h8;
    localparam logic [3:0] OP_SHR   = 4'h9;
    localparam logic [3:0] OP_PASS1 = 4'hA;
    localparam logic [3:0] OP_PASS2 = 4'hB;
    localparam logic [3:0] OP_MUL   = 4'hC;

    localparam logic [1:0] CS_ALU  = 2'b00;
    localparam logic [1:0] CS_KEEP = 2'b01;
    localparam logic [1:0] CS_SET  = 2'b10;
    localparam logic [1:0] CS_CLR  = 2'b11;

    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;

    // Z and N always follow the result; C is chosen by carry_sel.
    function automatic logic [2:0] ccr_next(input logic [2:0] old_ccr,
                                            input logic       z,
                                            input logic       n,
                                            input logic       alu_c,
                                            input logic [1:0] csel);
        logic [2:0] nxt;
        nxt        = '0;
        nxt[CCR_Z] = z;
        nxt[CCR_N] = n;
        case (csel)
            CS_ALU:  nxt[CCR_C] = alu_c;
            CS_KEEP: nxt[CCR_C] = old_ccr[CCR_C];
            CS_SET:  nxt[CCR_C] = 1'b1;
            default: nxt[CCR_C] = 1'b0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/exec_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per clock.
//   clk     : rising-edge clock
//   abort   : synchronous clear of the busy state (flush or reset from the top)
//   start   : load a / b and begin; ignored while busy
//   a, b    : WIDTH-bit unsigned operands
//   busy    : high from the cycle after start until the final step
//   done    : high during the last step; product is valid in that cycle
//   product : 2*WIDTH-bit product, combinational, meaningful only with done
// start-to-done-edge takes WIDTH clock edges after the loading edge.
module exec_mul_iter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 abort,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_d;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    // Partial sum including this cycle's multiplier bit; on the last step this
    // is already the full product, so the top can register it directly.
    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign product = acc_d;
    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (abort) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (start && !busy_q) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= {{WIDTH{1'b0}}, a};
            mplier_q <= b;
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + CW'(1);
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/exec_unit_param.sv
// Execute stage: WIDTH-bit ALU with registered result, result_hi and CCR,
// valid/ready input handshake, iterative multiplier and pipeline flush.
//   clk, reset (sync, active-low), flush
//   in_valid / in_ready       : input handshake; in_ready low while MUL busy
//   op1, op2, alu_op          : operands and opcode (op2 LSBs = shift amount)
//   carry_sel, flags_we       : C-flag source and CCR write enable
//   out_valid                 : one-cycle pulse per completed op
//   result, result_hi         : registered result (MUL high word in result_hi)
//   ccr                       : {C, N, Z}
module exec_unit_param
    import exec_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int OP_W  = 4,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  op1,
    input  logic [WIDTH-1:0]  op2,
    input  logic [OP_W-1:0]   alu_op,
    input  logic [1:0]        carry_sel,
    input  logic              flags_we,
    output logic              out_valid,
    output logic [WIDTH-1:0]  result,
    output logic [WIDTH-1:0]  result_hi,
    output logic [2:0]        ccr
);

    localparam logic [WIDTH:0] ONE_W = {{WIDTH{1'b0}}, 1'b1};

    logic [WIDTH-1:0]   result_q;
    logic [WIDTH-1:0]   result_hi_q;
    logic [2:0]         ccr_q;
    logic               out_valid_q;
    logic [1:0]         mul_csel_q;
    logic               mul_fwe_q;

    logic               accept;
    logic               is_mul;
    logic               op_single;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic [WIDTH:0]     wide;
    logic [SH_W-1:0]    sh_amt;

    logic               mul_busy;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   mul_lo;
    logic [WIDTH-1:0]   mul_hi;

    assign in_ready = ~mul_busy;
    assign accept   = in_valid & in_ready & ~flush;
    assign is_mul   = (alu_op == OP_W'(OP_MUL));
    assign sh_amt   = op2[SH_W-1:0];
    assign mul_lo   = mul_prod[WIDTH-1:0];
    assign mul_hi   = mul_prod[2*WIDTH-1:WIDTH];

    exec_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .abort   (flush | ~reset),
        .start   (accept & is_mul),
        .a       (op1),
        .b       (op2),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Single-cycle ALU. The extra top bit of `wide` carries out of (or the
    // borrow into) bit WIDTH-1; for shifts it captures the last bit shifted
    // out, which is naturally 0 for a shift amount of zero.
    always_comb begin
        alu_res   = '0;
        alu_c     = 1'b0;
        wide      = '0;
        op_single = 1'b1;
        case (alu_op)
            OP_W'(OP_NOT):   alu_res = ~op1;
            OP_W'(OP_INC): begin
                wide             = {1'b0, op1} + ONE_W;
                {alu_c, alu_res} = wide;
            end
            OP_W'(OP_DEC): begin
                wide             = {1'b0, op1} - ONE_W;
                {alu_c, alu_res} = wide;
            end
            OP_W'(OP_ADD): begin
                wide             = {1'b0, op1} + {1'b0, op2};
                {alu_c, alu_res} = wide;
            end
            OP_W'(OP_SUB): begin
                wide             = {1'b0, op1} - {1'b0, op2};
                {alu_c, alu_res} = wide;
            end
            OP_W'(OP_AND):   alu_res = op1 & op2;
            OP_W'(OP_OR):    alu_res = op1 | op2;
            OP_W'(OP_SHL): begin
                wide             = {1'b0, op1} << sh_amt;
                {alu_c, alu_res} = wide;
            end
            OP_W'(OP_SHR): begin
                wide             = {op1, 1'b0} >> sh_amt;
                {alu_res, alu_c} = wide;
            end
            OP_W'(OP_PASS1): alu_res = op1;
            OP_W'(OP_PASS2): alu_res = op2;
            default:         op_single = 1'b0;   // NOP, MUL and unused codes
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q    <= '0;
            result_hi_q <= '0;
            ccr_q       <= '0;
            out_valid_q <= 1'b0;
            mul_csel_q  <= CS_ALU;
            mul_fwe_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            // A finishing multiply and a new accept cannot coincide because
            // in_ready is low for the whole multiply.
            if (mul_done && !flush) begin
                result_q    <= mul_lo;
                result_hi_q <= mul_hi;
                out_valid_q <= 1'b1;
                if (mul_fwe_q) begin
                    ccr_q <= ccr_next(ccr_q, (mul_lo == '0), mul_lo[WIDTH-1],
                                      |mul_hi, mul_csel_q);
                end
            end else if (accept && op_single) begin
                result_q    <= alu_res;
                result_hi_q <= '0;
                out_valid_q <= 1'b1;
                if (flags_we) begin
                    ccr_q <= ccr_next(ccr_q, (alu_res == '0), alu_res[WIDTH-1],
                                      alu_c, carry_sel);
                end
            end
            // Flag controls of a multiply are applied at completion.
            if (accept && is_mul) begin
                mul_csel_q <= carry_sel;
                mul_fwe_q  <= flags_we;
            end
        end
    end

    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign ccr       = ccr_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_exec_unit_param.sv
// Directed-vector bench for exec_unit_param (WIDTH=16). Inputs change #1
// after a rising edge; outputs are sampled at that same point.
module tb_exec_unit_param;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] op1;
    logic [15:0] op2;
    logic [3:0]  alu_op;
    logic [1:0]  carry_sel;
    logic        flags_we;
    logic        out_valid;
    logic [15:0] result;
    logic [15:0] result_hi;
    logic [2:0]  ccr;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    exec_unit_param #(
        .WIDTH (16),
        .OP_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .alu_op    (alu_op),
        .carry_sel (carry_sel),
        .flags_we  (flags_we),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .ccr       (ccr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op for a single edge, then drop in_valid.
    task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] cs, input logic fwe);
        alu_op    = op;
        op1       = a;
        op2       = b;
        carry_sel = cs;
        flags_we  = fwe;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] r, input logic [15:0] rh,
                              input logic [2:0] c);
        chk({tag, ".valid"}, 32'(out_valid), 1);
        chk({tag, ".res"},   32'(result),    32'(r));
        chk({tag, ".hi"},    32'(result_hi), 32'(rh));
        chk({tag, ".ccr"},   32'(ccr),       32'(c));
    endtask

    int edges;
    int busy_cyc;
    int stray;

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        op1 = '0; op2 = '0; alu_op = '0; carry_sel = '0; flags_we = 1'b0;
        tick();
        tick();
        chk("rst.res",   32'(result),    0);
        chk("rst.hi",    32'(result_hi), 0);
        chk("rst.ccr",   32'(ccr),       0);
        chk("rst.valid", 32'(out_valid), 0);
        chk("rst.ready", 32'(in_ready),  1);
        reset = 1'b1;
        tick();

        // Basic arithmetic and flags
        issue(4'h4, 16'd15, 16'd24, 2'b00, 1'b1);
        expect_out("add15_24", 16'd39, 16'h0, 3'b000);
        tick();
        chk("pulse.valid", 32'(out_valid), 0);
        issue(4'h4, 16'hFFFF, 16'h0001, 2'b00, 1'b1);
        expect_out("add_wrap", 16'h0000, 16'h0, 3'b101);
        issue(4'h5, 16'd5, 16'd7, 2'b00, 1'b1);
        expect_out("sub5_7", 16'hFFFE, 16'h0, 3'b110);
        issue(4'h1, 16'd42, 16'd0, 2'b10, 1'b1);
        expect_out("not42", 16'hFFD5, 16'h0, 3'b110);
        issue(4'hA, 16'd10, 16'd0, 2'b00, 1'b0);
        expect_out("pass1_nofl", 16'd10, 16'h0, 3'b110);
        issue(4'hB, 16'd3, 16'd0, 2'b00, 1'b0);
        expect_out("pass2_nofl", 16'd0, 16'h0, 3'b110);
        issue(4'h0, 16'd9, 16'd9, 2'b00, 1'b1);
        chk("nop.valid", 32'(out_valid), 0);
        chk("nop.res",   32'(result),    0);
        chk("nop.ccr",   32'(ccr),       3'b110);
        issue(4'hE, 16'd9, 16'd9, 2'b00, 1'b1);
        chk("illegal.valid", 32'(out_valid), 0);
        issue(4'h2, 16'hFFFF, 16'd0, 2'b00, 1'b1);
        expect_out("inc_wrap", 16'h0000, 16'h0, 3'b101);
        issue(4'h3, 16'h0000, 16'd0, 2'b00, 1'b1);
        expect_out("dec_zero", 16'hFFFF, 16'h0, 3'b110);
        issue(4'h3, 16'h0005, 16'd0, 2'b01, 1'b1);
        expect_out("dec_keepc", 16'h0004, 16'h0, 3'b100);
        issue(4'h6, 16'hF0F0, 16'h3C3C, 2'b00, 1'b1);
        expect_out("and", 16'h3030, 16'h0, 3'b000);
        issue(4'h7, 16'hF000, 16'h000F, 2'b11, 1'b1);
        expect_out("or", 16'hF00F, 16'h0, 3'b010);
        issue(4'h8, 16'h8000, 16'h0000, 2'b00, 1'b1);
        expect_out("shl_by0", 16'h8000, 16'h0, 3'b010);
        issue(4'h9, 16'h8421, 16'h0004, 2'b00, 1'b1);
        expect_out("shr_by4", 16'h0842, 16'h0, 3'b000);

        // Multiply 300*300 with an ADD held waiting during busy
        issue(4'hC, 16'd300, 16'd300, 2'b00, 1'b1);
        alu_op = 4'h4; op1 = 16'd1; op2 = 16'd1; carry_sel = 2'b00; flags_we = 1'b1;
        in_valid = 1'b1;
        edges = 1;
        busy_cyc = 0;
        while (!out_valid && edges < 40) begin
            if (!in_ready) busy_cyc++;
            tick();
            edges++;
        end
        chk("mul.edges", 32'(edges), 17);
        chk("mul.busy_cycles", 32'(busy_cyc), 16);
        chk("mul.ready_back", 32'(in_ready), 1);
        expect_out("mul300", 16'h5F90, 16'h0001, 3'b100);
        tick();
        in_valid = 1'b0;
        expect_out("held_add", 16'd2, 16'h0, 3'b000);

        // Flush during a multiply
        issue(4'hC, 16'd7, 16'd9, 2'b00, 1'b1);
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush.valid", 32'(out_valid), 0);
        chk("flush.ready", 32'(in_ready),  1);
        chk("flush.res",   32'(result),    2);
        chk("flush.ccr",   32'(ccr),       0);
        stray = 0;
        repeat (20) begin
            tick();
            if (out_valid) stray++;
        end
        chk("flush.no_out", 32'(stray), 0);
        issue(4'h4, 16'd2, 16'd5, 2'b00, 1'b1);
        expect_out("add2_5", 16'd7, 16'h0, 3'b000);
        flush = 1'b1;
        issue(4'h4, 16'd3, 16'd3, 2'b00, 1'b1);
        flush = 1'b0;
        chk("flush_idle.valid", 32'(out_valid), 0);
        chk("flush_idle.res",   32'(result),    7);

        // Reset in the middle of a multiply
        issue(4'h1, 16'h0000, 16'd0, 2'b10, 1'b1);   // leave non-reset state behind
        issue(4'hC, 16'd300, 16'd300, 2'b00, 1'b1);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("midrst.res",   32'(result),    0);
        chk("midrst.hi",    32'(result_hi), 0);
        chk("midrst.ccr",   32'(ccr),       0);
        chk("midrst.valid", 32'(out_valid), 0);
        chk("midrst.ready", 32'(in_ready),  1);
        reset = 1'b1;
        stray = 0;
        repeat (20) begin
            tick();
            if (out_valid) stray++;
        end
        chk("midrst.no_out", 32'(stray), 0);

        // Back-to-back shifts on consecutive edges
        issue(4'h8, 16'h8001, 16'd1, 2'b00, 1'b1);
        expect_out("shl8001", 16'h0002, 16'h0, 3'b100);
        issue(4'h9, 16'h0003, 16'd1, 2'b00, 1'b1);
        expect_out("shr0003", 16'h0001, 16'h0, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/exec_unit_param.md
Name: exec_unit_param

Overview:
Parametrised next-generation execute stage for the pipelined RISC core: WIDTH-bit ALU with an extended opcode set, registered result and condition-code register (CCR), and a valid/ready handshake. Adds an iterative multi-cycle multiplier that back-pressures decode while busy, plus a pipeline flush. Sits between the decode/register-read stage and the memory stage.

Parameters:
WIDTH, 16, operand/result width (>=4, power of two)
OP_W, 4, ALU opcode width
SH_W, $clog2(WIDTH), shift-amount width taken from op2 LSBs

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
flush  in  1  kill in-flight op and this cycle's input
in_valid  in  1  operands/opcode valid
in_ready  out  1  stage can accept; low while multiply busy
op1  in  WIDTH  operand 1
op2  in  WIDTH  operand 2 / shift amount
alu_op  in  OP_W  opcode
carry_sel  in  2  00 C from ALU, 01 keep, 10 set, 11 clear
flags_we  in  1  update CCR for this op
out_valid  out  1  result valid (one-cycle pulse per op)
result  out  WIDTH  registered result (low word for MUL)
result_hi  out  WIDTH  MUL high word; 0 for other ops
ccr  out  3  [0] Z, [1] N, [2] C

Behaviour:
- Reset (reset==0 at clk edge): result=0, result_hi=0, ccr=3'b000, out_valid=0, in_ready=1, multiplier idle; also aborts any multiply in progress.
- Accept = in_valid & in_ready & ~flush.
- Opcodes: 0 NOP, 1 NOT, 2 INC, 3 DEC, 4 ADD, 5 SUB (op1-op2), 6 AND, 7 OR, 8 SHL, 9 SHR (logical), A PASS op1, B PASS op2, C MUL (unsigned), D-F treated as NOP.
- Single-cycle ops: result/result_hi/ccr/out_valid registered on the edge of accept; latency 1; back-to-back accepts every cycle.
- NOP / illegal op: out_valid=0; result, result_hi, ccr hold.
- ALU carry: ADD/INC = carry out of bit WIDTH-1; SUB/DEC = borrow (1 when op1<op2 unsigned); SHL/SHR = last bit shifted out (0 when amount is 0); NOT/AND/OR/PASS = 0.
- Z = (result==0); N = result[WIDTH-1]; C per carry_sel (01 keeps old C, 10 forces 1, 11 forces 0).
- flags_we=0: ccr holds entirely, result still updates.
- MUL: on accept, in_ready drops the next cycle; shift-add for WIDTH cycles; on completion {result_hi,result}=op1*op2, out_valid pulses, in_ready returns to 1 in the same cycle. Accept-to-out_valid = WIDTH+1 edges. Z/N from the low word; ALU C = |result_hi.
- in_valid while busy: ignored (the upstream stage holds it). No input is lost because in_ready=0.
- flush: cancels a busy multiply (no out_valid, ccr/result hold), drops same-cycle input, in_ready=1 next cycle. flush while idle suppresses out_valid for that input.
- flush and reset together: reset wins.
- Arithmetic is modulo 2^WIDTH; no signed overflow flag.

Decomposition:
- Package exec_pkg: opcode localparams (OP_NOP..OP_MUL), carry_sel codes (CS_ALU, CS_KEEP, CS_SET, CS_CLR), CCR bit indices (CCR_Z, CCR_N, CCR_C).
- Sub-module exec_mul_iter (WIDTH): start/busy/done handshake, 2*WIDTH product, abort input driven by flush|~reset.
- Combinational ALU and CCR logic live in the top.

Test Plan:
- ADD 15+24, carry_sel=00, flags_we=1 -> next cycle result=39, ccr=3'b000, out_valid=1.
- ADD 0xFFFF+0x0001 -> result=0x0000, ccr=3'b101; then SUB 5-7 -> result=0xFFFE, ccr=3'b110.
- NOT 42 with carry_sel=10, then PASS op1=10 with flags_we=0 -> 0xFFD5, ccr=3'b110; then result=10, ccr stays 3'b110.
- MUL 300*300 -> in_ready=0 for 16 cycles; out_valid 17 edges after accept; result=0x5F90, result_hi=0x0001, ccr=3'b100. Present an ADD during busy -> ignored until in_ready=1.
- Flush at busy cycle 5 of a MUL -> no out_valid, ccr/result unchanged, in_ready=1 next cycle; the following ADD 2+5 -> 7.
- Reset asserted mid-MUL -> all outputs return to reset values, in_ready=1. Back-to-back SHL 0x8001 by 1 and SHR 0x0003 by 1 -> 0x0002 with C=1, then 0x0001 with C=1, on consecutive cycles.
